// File: rtl/dmem_arb_pkg.sv
// Package for the data-memory arbiter.
// Holds the arbiter FSM state type, default geometry of the shared RAM,
// requester port ids, Y86 status codes used by the pipeline when it maps
// an arbiter address error, and a small address range helper.
package dmem_arb_pkg;

  localparam int DMEM_DW    = 64;   // data width
  localparam int DMEM_AW    = 8;    // RAM address width
  localparam int DMEM_DEPTH = 256;  // RAM words, equals 2**DMEM_AW

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // Requester ids; also the encoding of last_gnt and gnt_id.
  localparam logic P_PIPE = 1'b0;   // pipeline memory stage
  localparam logic P_LOAD = 1'b1;   // program loader / debug port

  // Y86 status codes relevant to data-memory accesses.
  localparam logic [3:0] STAT_AOK = 4'd1;
  localparam logic [3:0] STAT_ADR = 4'd3;

  // True when a 64-bit word address falls inside a RAM of 'depth' words.
  function automatic logic addr_in_range(input logic [63:0] addr, input int depth);
    return addr < 64'(depth);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker, purely combinational.
// Ports:
//   req[1:0]  in   request vector, bit i = port i
//   last_gnt  in   id of the port granted most recently
//   gnt[1:0]  out  one-hot grant (all zero when no request)
//   gnt_id    out  id of the granted port (P_PIPE when nothing granted)
// The last_gnt register itself lives in the instantiating module.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // Contention: the port that did not win last time goes first.
      2'b11:   gnt = (last_gnt == P_LOAD) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    gnt_id = gnt[1];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-ported synchronous data RAM between the
// pipeline memory stage (port 0) and the program loader / debug port (port 1).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   pN_req/we/addr/wdata    request from port N (N = 0, 1); 64-bit word address
//   pN_gnt                  combinational 1-cycle pulse: request accepted this cycle
//   pN_rvalid               1-cycle pulse two cycles after pN_gnt: access complete
//   pN_rdata                read data, non-zero only while pN_rvalid on a good read
//   pN_err                  address error, qualified by pN_rvalid
//   mem_en/we/addr/wdata    registered RAM controls
//   mem_rdata               RAM read data, valid the cycle after a read enable
//   busy                    FSM not idle
//   fsm_state               current FSM state, for observation
//
// Handshake: a requester raises pN_req with we/addr/wdata and holds all of
// them stable until it sees pN_gnt high in a cycle; the request is taken at
// the end of that cycle and may be dropped or replaced from the next cycle.
// Dropping req before a grant cancels it without side effects. Exactly one
// pN_rvalid pulse follows every grant (unless reset intervenes), two cycles
// after the grant.
//
// Configuration macro DMEM_ARB_ADDR_CHECK_EN: when defined, addresses at or
// above DEPTH skip the RAM and complete with pN_err=1 and rdata=0; when not
// defined the address wraps to addr[AW-1:0] and pN_err is always 0.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DW    = DMEM_DW,
  parameter int AW    = DMEM_AW,
  parameter int DEPTH = DMEM_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [63:0]   p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_err,

  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [63:0]   p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_err,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic          busy,
  output arb_state_t    fsm_state
);

  // The RAM geometry must be consistent; catch a bad override at elaboration.
  if (DEPTH != (1 << AW)) begin : g_bad_depth
    $error("dmem_arbiter: DEPTH must equal 2**AW");
  end

  logic          last_gnt;   // id of the most recently granted port
  logic          lat_port;   // port owning the access in flight
  logic          lat_we;     // access in flight is a write
  logic          lat_err;    // access in flight has an out-of-range address

  logic [1:0]    req_vec;
  logic [1:0]    pick;
  logic          pick_id;
  logic          arb_en;
  logic          any_gnt;

  logic          sel_we;
  logic [63:0]   sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_bad;

  assign req_vec = {p1_req, p0_req};

  rr_arb2 u_rr_arb2 (
    .req      (req_vec),
    .last_gnt (last_gnt),
    .gnt      (pick),
    .gnt_id   (pick_id)
  );

  // Grants are only issued where the FSM can start a new access. Gating with
  // rst_n keeps gnt low while reset is held even if a requester is active.
  assign arb_en  = rst_n && ((fsm_state == IDLE) || (fsm_state == RESP));
  assign p0_gnt  = arb_en & pick[0];
  assign p1_gnt  = arb_en & pick[1];
  assign any_gnt = p0_gnt | p1_gnt;

  // Fields of the winning request, captured into the RAM registers at the
  // end of the grant cycle.
  assign sel_we    = (pick_id == P_LOAD) ? p1_we    : p0_we;
  assign sel_addr  = (pick_id == P_LOAD) ? p1_addr  : p0_addr;
  assign sel_wdata = (pick_id == P_LOAD) ? p1_wdata : p0_wdata;

`ifdef DMEM_ARB_ADDR_CHECK_EN
  assign sel_bad = !addr_in_range(sel_addr, DEPTH);
`else
  // Upper address bits are ignored: the address wraps modulo DEPTH.
  assign sel_bad = 1'b0;
  logic unused_addr_hi;
  assign unused_addr_hi = ^sel_addr[63:AW];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_state <= IDLE;
      last_gnt  <= P_LOAD;
      lat_port  <= P_PIPE;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_err    <= 1'b0;
      p1_err    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      // Response strobes are single-cycle pulses.
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_err    <= 1'b0;
      p1_err    <= 1'b0;
      case (fsm_state)
        IDLE, RESP: begin
          if (any_gnt) begin
            fsm_state <= ACCESS;
            last_gnt  <= pick_id;
            lat_port  <= pick_id;
            lat_we    <= sel_we;
            lat_err   <= sel_bad;
            // A bad address never reaches the RAM.
            mem_en    <= ~sel_bad;
            mem_we    <= sel_we & ~sel_bad;
            mem_addr  <= sel_addr[AW-1:0];
            mem_wdata <= sel_wdata;
          end else begin
            fsm_state <= IDLE;
          end
        end
        ACCESS: begin
          fsm_state <= RESP;
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          if (lat_port == P_PIPE) begin
            p0_rvalid <= 1'b1;
            p0_err    <= lat_err;
          end else begin
            p1_rvalid <= 1'b1;
            p1_err    <= lat_err;
          end
        end
        default: fsm_state <= IDLE;
      endcase
    end
  end

  // RAM read data appears in RESP, the cycle rvalid is high; writes and
  // failed accesses return zero.
  assign p0_rdata = (p0_rvalid && !lat_we && !lat_err) ? mem_rdata : '0;
  assign p1_rdata = (p1_rvalid && !lat_we && !lat_err) ? mem_rdata : '0;

  assign busy = (fsm_state != IDLE);

endmodule
